multi_div_ticker: RTL and testbench

MULTI_DIV_TICKER -- requirements
Module: multi_div_ticker

---
 rtl/multi_div_ticker.sv | 142 ++++++++++++++
 tb/tb_multi_div_ticker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_div_ticker.sv
// Free-running modulo-P counter with N_CH divisor channels flagging "count is a
// multiple of div[i]", plus a one-deep event register with a sticky drop flag.
module multi_div_ticker #(
  parameter int unsigned          N_CH        = 3,
  parameter int unsigned          W           = 8,
  parameter logic [W-1:0]         PERIOD_INIT = W'(100),
  parameter logic [N_CH*W-1:0]    DIV_INIT    = {8'd7, 8'd5, 8'd3},
  localparam int unsigned         AW          = $clog2(N_CH + 1)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            en,
  input  logic            clr,
  input  logic            cfg_we,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [W-1:0]    cfg_wdata,
  output logic [W-1:0]    count,
  output logic [N_CH-1:0] hit,
  output logic            all_hit,
  output logic            any_hit,
  output logic            wrap,
  output logic            ev_valid,
  output logic [W-1:0]    ev_count,
  output logic [N_CH-1:0] ev_hit,
  input  logic            ev_ready,
  output logic            ovf
);

  localparam logic [AW-1:0] PERIOD_ADDR = AW'(N_CH);

  logic [W-1:0]    period_q, period_d;
  logic [W-1:0]    count_q, count_d;
  logic [W-1:0]    div_q [N_CH];
  logic [W-1:0]    div_d [N_CH];
  logic [W-1:0]    res_q [N_CH];
  logic [W-1:0]    res_d [N_CH];
  logic            ovf_q, ovf_d;
  logic            ev_valid_q, ev_valid_d;
  logic [W-1:0]    ev_count_q, ev_count_d;
  logic [N_CH-1:0] ev_hit_q, ev_hit_d;

  logic [W-1:0]    last_cnt;
  logic [N_CH-1:0] div_sel;
  logic            per_sel;
  logic            cfg_ok;
  logic            ev_gen;

  // Residues track count mod div[i] incrementally, so hit needs no divider.
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      hit[i]     = (div_q[i] != '0) && (res_q[i] == '0);
      div_sel[i] = (cfg_addr == AW'(i));
    end
    per_sel  = (cfg_addr == PERIOD_ADDR);
    cfg_ok   = per_sel || (div_sel != '0);
    last_cnt = (period_q == '0) ? '0 : period_q - W'(1);
    wrap     = en && (count_q == last_cnt);
    all_hit  = &hit;
    any_hit  = |hit;
  end

  always_comb begin
    period_d   = period_q;
    count_d    = count_q;
    div_d      = div_q;
    res_d      = res_q;
    ovf_d      = ovf_q;
    ev_valid_d = ev_valid_q;
    ev_count_d = ev_count_q;
    ev_hit_d   = ev_hit_q;
    ev_gen     = en && !cfg_we && !clr && any_hit;

    // Event register follows the consumer handshake independently of the
    // count-update priority below; only clr touches ovf from that side.
    if (ev_gen) begin
      if (!ev_valid_q || ev_ready) begin
        ev_valid_d = 1'b1;
        ev_count_d = count_q;
        ev_hit_d   = hit;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (ev_ready) begin
      ev_valid_d = 1'b0;
    end

    if (cfg_we) begin
      if (cfg_ok) begin
        if (per_sel) period_d = cfg_wdata;
        for (int unsigned i = 0; i < N_CH; i++) begin
          if (div_sel[i]) div_d[i] = cfg_wdata;
          res_d[i] = '0;
        end
        count_d = '0;
      end
    end else if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) res_d[i] = '0;
    end else if (en) begin
      if (wrap) begin
        count_d = '0;
        for (int unsigned i = 0; i < N_CH; i++) res_d[i] = '0;
      end else begin
        count_d = count_q + W'(1);
        for (int unsigned i = 0; i < N_CH; i++)
          res_d[i] = (res_q[i] == div_q[i] - W'(1)) ? '0 : res_q[i] + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      period_q   <= PERIOD_INIT;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      ev_valid_q <= 1'b0;
      ev_count_q <= '0;
      ev_hit_q   <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        div_q[i] <= DIV_INIT[i*W +: W];
        res_q[i] <= '0;
      end
    end else begin
      period_q   <= period_d;
      count_q    <= count_d;
      div_q      <= div_d;
      res_q      <= res_d;
      ovf_q      <= ovf_d;
      ev_valid_q <= ev_valid_d;
      ev_count_q <= ev_count_d;
      ev_hit_q   <= ev_hit_d;
    end
  end

  assign count    = count_q;
  assign ovf      = ovf_q;
  assign ev_valid = ev_valid_q;
  assign ev_count = ev_count_q;
  assign ev_hit   = ev_hit_q;

endmodule

// File: tb/tb_multi_div_ticker.sv
// Bench for multi_div_ticker: reference model using %, event scoreboard queue,
// a vector table for the first 16 counts and directed corner-case sequences.
module tb_multi_div_ticker;

  logic       clk = 1'b0;
  logic       resetn, en, clr, cfg_we, ev_ready;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] count, ev_count;
  logic [2:0] hit, ev_hit;
  logic       all_hit, any_hit, wrap, ev_valid, ovf;

  int checks = 0;
  int errors = 0;

  int unsigned m_count, m_period;
  int unsigned m_div [3];
  bit          m_evv, m_ovf;
  int unsigned m_evc;
  bit [2:0]    m_evh;

  typedef struct { int unsigned cnt; bit [2:0] h; } ev_t;
  ev_t sb [$];

  typedef struct { bit en; bit rdy; int unsigned exp_cnt; bit [2:0] exp_hit; } vec_t;
  vec_t tbl [16];

  always #5 clk = ~clk;

  multi_div_ticker #(.N_CH(3), .W(8)) dut (
    .clk(clk), .resetn(resetn), .en(en), .clr(clr), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .count(count), .hit(hit),
    .all_hit(all_hit), .any_hit(any_hit), .wrap(wrap), .ev_valid(ev_valid),
    .ev_count(ev_count), .ev_hit(ev_hit), .ev_ready(ev_ready), .ovf(ovf)
  );

  function automatic bit [2:0] m_hit();
    bit [2:0] h;
    for (int i = 0; i < 3; i++) h[i] = (m_div[i] != 0) && ((m_count % m_div[i]) == 0);
    return h;
  endfunction

  function automatic bit m_wrap(bit e);
    int unsigned p;
    p = (m_period == 0) ? 1 : m_period;
    return e && (m_count == p - 1);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_period = 100; m_div = '{3, 5, 7};
    m_evv = 0; m_evc = 0; m_evh = 0; m_ovf = 0;
    sb.delete();
  endtask

  // One clock: drive at negedge, compare pre-edge outputs, advance model.
  task automatic cyc(bit rn, bit e, bit c, bit we, bit [1:0] a, bit [7:0] d, bit rdy);
    bit [2:0] h;
    bit       wr, gen;
    ev_t      x;
    @(negedge clk);
    resetn = rn; en = e; clr = c; cfg_we = we; cfg_addr = a; cfg_wdata = d; ev_ready = rdy;
    #1;
    h  = m_hit();
    wr = m_wrap(e);
    chk("count",    32'(count),    m_count);
    chk("hit",      32'(hit),      32'(h));
    chk("all_hit",  32'(all_hit),  32'(&h));
    chk("any_hit",  32'(any_hit),  32'(|h));
    chk("wrap",     32'(wrap),     32'(wr));
    chk("ev_valid", 32'(ev_valid), 32'(m_evv));
    chk("ovf",      32'(ovf),      32'(m_ovf));
    if (m_evv) begin
      chk("ev_count", 32'(ev_count), m_evc);
      chk("ev_hit",   32'(ev_hit),   32'(m_evh));
    end
    if (ev_valid && rdy) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty: got event %0d expected none", ev_count);
      end else begin
        x = sb.pop_front();
        chk("sb_ev_count", 32'(ev_count), x.cnt);
        chk("sb_ev_hit",   32'(ev_hit),   32'(x.h));
      end
    end
    if (!rn) begin
      model_reset();
    end else begin
      gen = e && !we && !c && (h != 0);
      if (gen) begin
        if (!m_evv || rdy) begin
          m_evv = 1; m_evc = m_count; m_evh = h;
          sb.push_back('{m_count, h});
        end else m_ovf = 1;
      end else if (rdy) m_evv = 0;
      if (we) begin
        if (a == 2'd3) m_period = d; else m_div[a] = d;
        m_count = 0;
      end else if (c) begin
        m_count = 0; m_ovf = 0;
      end else if (e) begin
        m_count = wr ? 0 : m_count + 1;
      end
    end
  endtask

  task automatic run(bit rdy);   cyc(1, 1, 0, 0, 2'd0, 8'd0, rdy); endtask
  task automatic idle(bit rdy);  cyc(1, 0, 0, 0, 2'd0, 8'd0, rdy); endtask
  task automatic rst();          cyc(0, 0, 0, 0, 2'd0, 8'd0, 1);   endtask
  task automatic wr_cfg(bit [1:0] a, bit [7:0] d); cyc(1, 1, 0, 1, a, d, 1); endtask

  task automatic run_to(int unsigned target);
    for (int g = 0; g < 300 && m_count != target; g++) run(1);
    if (m_count != target) begin
      checks++; errors++;
      $display("FAIL run_to: got count %0d expected %0d", m_count, target);
    end
  endtask

  bit [2:0] hv [16] = '{3'b111, 3'b000, 3'b000, 3'b001, 3'b000, 3'b010, 3'b001, 3'b100,
                        3'b000, 3'b001, 3'b010, 3'b000, 3'b001, 3'b000, 3'b100, 3'b011};

  initial begin
    int unsigned wrap_cnt;
    bit          seen;
    resetn = 0; en = 0; clr = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; ev_ready = 1;
    repeat (3) @(posedge clk);
    model_reset();

    for (int k = 0; k < 16; k++) tbl[k] = '{1'b1, 1'b1, k, hv[k]};
    for (int k = 0; k < 16; k++) begin
      cyc(1, tbl[k].en, 0, 0, 2'd0, 8'd0, tbl[k].rdy);
      chk("tbl_count", 32'(count), tbl[k].exp_cnt);
      chk("tbl_hit",   32'(hit),   32'(tbl[k].exp_hit));
    end

    // wrap at 99
    run_to(99);
    run(1);
    chk("wrap99", 32'(wrap), 32'd1);
    run(1);
    chk("after_wrap_count", 32'(count), 32'd0);
    chk("after_wrap_hit",   32'(hit),   32'd7);
    chk("ev_hit99",         32'(ev_hit), 32'd1);
    chk("ev_count99",       32'(ev_count), 32'd99);

    // divisor write mid-run
    run_to(10);
    wr_cfg(2'd0, 8'd4);
    run(1);
    chk("cfg_restart", 32'(count), 32'd0);
    run_to(3);
    run(1);
    chk("div4_c3", 32'(hit[0]), 32'd0);
    run(1);
    chk("div4_c4", 32'(hit[0]), 32'd1);

    // back-pressure, drop, ovf, clr
    rst();
    run(0); run(0); run(0); run(0);
    idle(1);
    chk("held_count", 32'(ev_count), 32'd0);
    chk("ovf_set",    32'(ovf),      32'd1);
    cyc(1, 0, 1, 0, 2'd0, 8'd0, 1);
    chk("drained", 32'(ev_valid), 32'd0);
    idle(0);
    chk("ovf_clr", 32'(ovf), 32'd0);
    run(0);
    cyc(1, 1, 1, 0, 2'd0, 8'd0, 0);
    idle(0);
    chk("clr_keeps_ev", 32'(ev_valid), 32'd1);
    idle(1);

    // period 0 and disabled channel
    wr_cfg(2'd3, 8'd0);
    for (int k = 0; k < 3; k++) begin
      run(1);
      chk("p0_count", 32'(count), 32'd0);
      chk("p0_wrap",  32'(wrap),  32'd1);
    end
    wr_cfg(2'd3, 8'd20);
    wr_cfg(2'd1, 8'd0);
    for (int k = 0; k < 12; k++) begin
      run(1);
      chk("div0_hit1", 32'(hit[1]), 32'd0);
    end

    // reset discards configuration
    rst();
    wr_cfg(2'd3, 8'd50);
    run_to(42);
    rst();
    seen = 0; wrap_cnt = 0;
    for (int g = 0; g < 150 && !seen; g++) begin
      run(1);
      if (wrap) begin seen = 1; wrap_cnt = 32'(count); end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL wrap_timeout: got no wrap expected wrap at 99");
    end else chk("wrap_at", wrap_cnt, 32'd99);

    // random mix
    for (int k = 0; k < 400; k++) begin
      bit [1:0] a;
      a = 2'($urandom_range(0, 3));
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 19) == 0, a,
          (a == 2'd3) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 9)),
          $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
